// File: rtl/result_pkg.sv
// Shared defaults and the buffered entry layout for the result collector.
package result_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int DATA_W_DEF = 32;

    // One buffered result at the default word width.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  ovf;
        logic                  ovf_valid;
    } entry_t;

endpackage

// File: rtl/result_buf_ram.sv
// Entry storage: one product write port, one flag-update port and a registered
// read port that forwards same-cycle writes so the head register never lags.
module result_buf_ram
    import result_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fl_en,
    input  logic [AW-1:0]     fl_addr,
    input  logic              fl_ovf,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ovf,
    output logic              rd_ovf_valid
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ovf;
        logic              ovf_valid;
    } slot_t;

    slot_t mem [DEPTH];
    slot_t rd_next;

    // Flag update is applied after the write so a product paired on its own
    // write cycle comes out complete.
    always_comb begin
        rd_next = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_next.data      = wr_data;
            rd_next.ovf_valid = 1'b0;
        end
        if (fl_en && (fl_addr == rd_addr)) begin
            rd_next.ovf       = fl_ovf;
            rd_next.ovf_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data      <= '0;
            rd_ovf       <= 1'b0;
            rd_ovf_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_addr].data      <= wr_data;
                mem[wr_addr].ovf_valid <= 1'b0;
            end
            if (fl_en) begin
                mem[fl_addr].ovf       <= fl_ovf;
                mem[fl_addr].ovf_valid <= 1'b1;
            end
            rd_data      <= rd_next.data;
            rd_ovf       <= rd_next.ovf;
            rd_ovf_valid <= rd_next.ovf_valid;
        end
    end

endmodule

// File: rtl/result_collector.sv
// Pairs multiplier products with late-arriving overflow flags and presents them in order.
// Optional pop statistics are built when RESULT_COLLECTOR_STATS_EN is defined.
module result_collector
    import result_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        c_in,
    input  logic                     we,
    input  logic                     overflow_in,
    input  logic                     we_ov,
    input  logic                     flush,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_ovf,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop_err,
    output logic                     orphan_err
`ifdef RESULT_COLLECTOR_STATS_EN
    ,
    output logic [15:0]              stat_results,
    output logic [15:0]              stat_ovf
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, ov_ptr, rd_ptr, ram_rd_addr;
    logic [AW:0]   pend;
    logic          push, pop, ov_ok, drop, orphan, head_ovf_valid;

    assign full     = (level == FULL_LVL);
    assign rd_valid = (level != '0) && head_ovf_valid;

    // Pending entries always sit at ov_ptr..wr_ptr-1; with none pending, a flag
    // may still pair with the product being written this cycle.
    assign push   = we && !full && !flush;
    assign pop    = rd_valid && rd_ready && !flush;
    assign ov_ok  = we_ov && !flush && ((pend != '0) || push);
    assign drop   = we && full && !flush;
    assign orphan = we_ov && !flush && !ov_ok;

    assign ram_rd_addr = flush ? '0 : rd_ptr + AW'(pop);

    result_buf_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (push),
        .wr_addr      (wr_ptr),
        .wr_data      (c_in),
        .fl_en        (ov_ok),
        .fl_addr      (ov_ptr),
        .fl_ovf       (overflow_in),
        .rd_addr      (ram_rd_addr),
        .rd_data      (rd_data),
        .rd_ovf       (rd_ovf),
        .rd_ovf_valid (head_ovf_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            ov_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            pend       <= '0;
            drop_err   <= 1'b0;
            orphan_err <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            ov_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            pend   <= '0;
        end else begin
            if (push)   wr_ptr     <= wr_ptr + 1'b1;
            if (ov_ok)  ov_ptr     <= ov_ptr + 1'b1;
            if (pop)    rd_ptr     <= rd_ptr + 1'b1;
            if (drop)   drop_err   <= 1'b1;
            if (orphan) orphan_err <= 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            pend  <= pend + (AW+1)'(push) - (AW+1)'(ov_ok);
        end
    end

`ifdef RESULT_COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_results <= '0;
            stat_ovf     <= '0;
        end else if (pop) begin
            if (stat_results != 16'hFFFF)   stat_results <= stat_results + 1'b1;
            if (rd_ovf && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector (DEPTH=8, DATA_W=32).
module tb_result_collector;

    logic        clk;
    logic        reset;
    logic [31:0] c_in;
    logic        we, overflow_in, we_ov, flush, rd_ready;
    logic        rd_valid, rd_ovf, full, drop_err, orphan_err;
    logic [31:0] rd_data;
    logic [3:0]  level;
`ifdef RESULT_COLLECTOR_STATS_EN
    logic [15:0] stat_results, stat_ovf;
`endif

    int total = 0;
    int bad   = 0;

    result_collector #(.DEPTH(8), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .c_in         (c_in),
        .we           (we),
        .overflow_in  (overflow_in),
        .we_ov        (we_ov),
        .flush        (flush),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ovf       (rd_ovf),
        .full         (full),
        .level        (level),
        .drop_err     (drop_err),
        .orphan_err   (orphan_err)
`ifdef RESULT_COLLECTOR_STATS_EN
        ,
        .stat_results (stat_results),
        .stat_ovf     (stat_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; c_in = '0; we = 1'b0; overflow_in = 1'b0;
        we_ov = 1'b0; flush = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; we = 1'b1; we_ov = 1'b1; flush = 1'b1; c_in = 32'hFFFF_FFFF; rd_ready = 1'b1;
        tick();
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        total++; if (rd_ovf !== 1'b0) begin bad++; $display("FAIL reset_rd_ovf got=%0b exp=0", rd_ovf); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (drop_err !== 1'b0 || orphan_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%0b%0b exp=00", drop_err, orphan_err); end
        idle();
    endtask

    task automatic test_basic();
        do_reset();
        we = 1'b1; c_in = 32'h3F80_0000;
        tick();
        idle();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_unpaired_valid got=%0b exp=0", rd_valid); end
        total++; if (level !== 4'd1) begin bad++; $display("FAIL basic_level got=%0d exp=1", level); end
        we_ov = 1'b1; overflow_in = 1'b0;
        tick();
        idle();
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", rd_valid); end
        total++; if (rd_data !== 32'h3F80_0000) begin bad++; $display("FAIL basic_data got=%h exp=3f800000", rd_data); end
        total++; if (rd_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%0b exp=0", rd_ovf); end
        rd_ready = 1'b1;
        tick();
        idle();
        total++; if (level !== 4'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL basic_pop got level=%0d valid=%0b exp 0 0", level, rd_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; we_ov = 1'b1; c_in = 32'hA000_0000 + 32'(i); overflow_in = i[0];
            tick();
        end
        idle();
        we = 1'b1; c_in = 32'hDEAD_BEEF;
        tick();
        idle();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%0b exp=1", full); end
        total++; if (level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d exp=8", level); end
        total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL full_drop_err got=%0b exp=1", drop_err); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_data !== 32'hA000_0000 + 32'(i) || rd_ovf !== i[0])
                begin bad++; $display("FAIL full_pop%0d got v=%0b d=%h o=%0b exp v=1 d=%h o=%0b", i, rd_valid, rd_data, rd_ovf, 32'hA000_0000 + 32'(i), i[0]); end
            rd_ready = 1'b1; we = (i == 0); c_in = 32'hDEAD_BEEF;
            tick();
            idle();
            if (i == 0) begin
                total++; if (level !== 4'd7) begin bad++; $display("FAIL full_drop_with_pop level got=%0d exp=7", level); end
            end
        end
        total++; if (level !== 4'd0 || rd_valid !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL full_drained got level=%0d valid=%0b full=%0b exp 0 0 0", level, rd_valid, full); end
    endtask

    // Runs straight after test_full so drop_err is already set.
    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; we_ov = 1'b1; c_in = 32'hC000_0000 + 32'(i);
            tick();
        end
        idle();
        total++; if (level !== 4'd5) begin bad++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
        flush = 1'b1; we = 1'b1; we_ov = 1'b1; rd_ready = 1'b1; c_in = 32'h1111_1111;
        tick();
        idle();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", rd_valid); end
        total++; if (drop_err !== 1'b1 || orphan_err !== 1'b0) begin bad++; $display("FAIL flush_errs got=%0b%0b exp=10", drop_err, orphan_err); end
        we = 1'b1; we_ov = 1'b1; overflow_in = 1'b1; c_in = 32'h2222_2222;
        tick();
        idle();
        total++; if (rd_valid !== 1'b1 || rd_data !== 32'h2222_2222 || rd_ovf !== 1'b1 || level !== 4'd1)
            begin bad++; $display("FAIL flush_restart got v=%0b d=%h o=%0b l=%0d exp v=1 d=22222222 o=1 l=1", rd_valid, rd_data, rd_ovf, level); end
    endtask

    task automatic test_orphan();
        do_reset();
        we_ov = 1'b1; overflow_in = 1'b1;
        tick();
        idle();
        total++; if (orphan_err !== 1'b1) begin bad++; $display("FAIL orphan_err got=%0b exp=1", orphan_err); end
        total++; if (level !== 4'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL orphan_state got level=%0d valid=%0b exp 0 0", level, rd_valid); end
    endtask

    task automatic test_flags();
        logic [2:0] ovs;
        ovs = 3'b101;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; c_in = 32'hD000_0001 + 32'(i);
            tick();
        end
        idle();
        total++; if (rd_valid !== 1'b0 || level !== 4'd3) begin bad++; $display("FAIL flags_noflag got valid=%0b level=%0d exp 0 3", rd_valid, level); end
        we_ov = 1'b1; overflow_in = ovs[0];
        tick();
        idle();
        total++; if (rd_valid !== 1'b1 || rd_data !== 32'hD000_0001 || rd_ovf !== 1'b1)
            begin bad++; $display("FAIL flags_first got v=%0b d=%h o=%0b exp v=1 d=d0000001 o=1", rd_valid, rd_data, rd_ovf); end
        for (int i = 1; i < 3; i++) begin
            we_ov = 1'b1; overflow_in = ovs[i];
            tick();
        end
        idle();
        total++; if (rd_data !== 32'hD000_0001 || rd_ovf !== 1'b1) begin bad++; $display("FAIL flags_hold got d=%h o=%0b exp d=d0000001 o=1", rd_data, rd_ovf); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_data !== 32'hD000_0001 + 32'(i) || rd_ovf !== ovs[i])
                begin bad++; $display("FAIL flags_pop%0d got v=%0b d=%h o=%0b exp o=%0b", i, rd_valid, rd_data, rd_ovf, ovs[i]); end
            rd_ready = 1'b1;
            tick();
            idle();
        end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL flags_drained got=%0d exp=0", level); end
    endtask

    // Streaming push+pop every cycle; pointers wrap past DEPTH-1.
    task automatic test_back_to_back();
        we = 1'b1; we_ov = 1'b1; c_in = 32'hB000_0000; overflow_in = 1'b1;
        tick();
        idle();
        for (int k = 1; k <= 10; k++) begin
            total++; if (rd_valid !== 1'b1 || rd_data !== 32'hB000_0000 + 32'(k-1) || rd_ovf !== ((k-1) % 3 == 0))
                begin bad++; $display("FAIL b2b_data%0d got v=%0b d=%h o=%0b", k, rd_valid, rd_data, rd_ovf); end
            we = 1'b1; we_ov = 1'b1; rd_ready = 1'b1; c_in = 32'hB000_0000 + 32'(k); overflow_in = (k % 3 == 0);
            tick();
            idle();
            total++; if (level !== 4'd1) begin bad++; $display("FAIL b2b_level%0d got=%0d exp=1", k, level); end
        end
        total++; if (rd_data !== 32'hB000_000A || rd_ovf !== 1'b0) begin bad++; $display("FAIL b2b_last got d=%h o=%0b exp d=b000000a o=0", rd_data, rd_ovf); end
        rd_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        we = 1'b1; we_ov = 1'b1; c_in = 32'h0000_0055;
        tick();
        we_ov = 1'b0; c_in = 32'h0000_0066;
        tick();
        idle();
        reset = 1'b1; we = 1'b1; flush = 1'b1;
        tick();
        idle();
        total++; if (level !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 32'h0)
            begin bad++; $display("FAIL rstmid_state got l=%0d v=%0b d=%h exp 0 0 0", level, rd_valid, rd_data); end
        we_ov = 1'b1;
        tick();
        idle();
        total++; if (orphan_err !== 1'b1 || level !== 4'd0) begin bad++; $display("FAIL rstmid_orphan got o=%0b l=%0d exp 1 0", orphan_err, level); end
    endtask

`ifdef RESULT_COLLECTOR_STATS_EN
    task automatic test_stats();
        do_reset();
        total++; if (stat_results !== 16'd0 || stat_ovf !== 16'd0) begin bad++; $display("FAIL stats_reset got %0d %0d exp 0 0", stat_results, stat_ovf); end
        for (int i = 0; i < 20; i++) begin
            we = 1'b1; we_ov = 1'b1; c_in = 32'(i); overflow_in = (i < 7);
            tick();
            idle();
            rd_ready = 1'b1;
            tick();
            idle();
        end
        total++; if (stat_results !== 16'd20) begin bad++; $display("FAIL stats_results got=%0d exp=20", stat_results); end
        total++; if (stat_ovf !== 16'd7) begin bad++; $display("FAIL stats_ovf got=%0d exp=7", stat_ovf); end
        flush = 1'b1;
        tick();
        idle();
        total++; if (stat_results !== 16'd20 || stat_ovf !== 16'd7) begin bad++; $display("FAIL stats_flush got %0d %0d exp 20 7", stat_results, stat_ovf); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_orphan();
        test_flags();
        test_back_to_back();
        test_reset_mid();
`ifdef RESULT_COLLECTOR_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of buffered result entries (power of two, at least 2).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the product word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port c_in, input, DATA_W bits: product word from the multiplier control unit.
REQ-006 The block SHALL have port we, input, 1 bit: c_in is valid this cycle.
REQ-007 The block SHALL have port overflow_in, input, 1 bit: overflow flag of a product.
REQ-008 The block SHALL have port we_ov, input, 1 bit: overflow_in is valid this cycle.
REQ-009 The block SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-010 The block SHALL have port rd_ready, input, 1 bit: the downstream side accepts the head entry.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: the head entry is complete and presented.
REQ-012 The block SHALL have port rd_data, output, DATA_W bits: head product word.
REQ-013 The block SHALL have port rd_ovf, output, 1 bit: head overflow flag.
REQ-014 The block SHALL have port full, output, 1 bit: all DEPTH entries are occupied.
REQ-015 The block SHALL have port level, output, log2(DEPTH)+1 bits: occupied entry count.
REQ-016 The block SHALL have port drop_err, output, 1 bit: sticky flag, a product was dropped.
REQ-017 The block SHALL have port orphan_err, output, 1 bit: sticky flag, an overflow flag arrived with no pending product.

Function
REQ-018 When we=1 and the buffer is not full, the block SHALL write c_in into the entry at the write pointer, mark that entry's ovf_valid=0, and advance the pointer modulo DEPTH.
REQ-019 When we_ov=1, the block SHALL store overflow_in into the oldest occupied entry with ovf_valid=0, set its ovf_valid, and advance the ovf pointer; this pairs a product with an overflow flag arriving on the same cycle or any later cycle.
REQ-020 When we_ov=1 on the same cycle as we into an otherwise fully paired buffer, the block SHALL pair the flag with the entry being written in that cycle.
REQ-021 When we_ov=1 and no entry is pending a flag (including that cycle's write), the block SHALL ignore the flag and set orphan_err.
REQ-022 When we=1 and full=1, the block SHALL drop the write and set drop_err, even if a pop occurs on the same cycle.
REQ-023 The block SHALL drive rd_valid=1 only when level>0 and the head entry has ovf_valid=1; rd_data and rd_ovf SHALL be driven from registered storage, with zero combinational path from c_in.
REQ-024 When rd_valid=1 and rd_ready=1, the block SHALL pop the head entry and advance the read pointer modulo DEPTH.
REQ-025 The block SHALL hold rd_data and rd_ovf stable while rd_valid=1 and rd_ready=0.
REQ-026 The first complete entry SHALL appear on rd_valid one cycle after the later of its we and we_ov cycles.
REQ-027 A simultaneous push and pop SHALL leave level unchanged.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of data or flags.
REQ-029 When flush=1, the block SHALL take priority over we, we_ov and pop: it SHALL empty the buffer, reset all pointers and level to 0, and leave drop_err and orphan_err unchanged.

Reset
REQ-030 While reset=1 on a clock edge, the block SHALL set rd_valid=0, rd_data=0, rd_ovf=0, full=0, level=0, drop_err=0, orphan_err=0, and all pointers to 0.
REQ-031 Reset SHALL take priority over flush and all other inputs.
REQ-032 A reset asserted mid-operation SHALL discard all buffered and partially paired entries.

Configuration
REQ-033 With RESULT_COLLECTOR_STATS_EN defined, the block SHALL add 16-bit outputs stat_results and stat_ovf: stat_results increments on each pop, and stat_ovf increments on each pop with rd_ovf=1.
REQ-034 Both statistics counters SHALL saturate at 16'hFFFF and SHALL clear on reset only, not on flush.
REQ-035 Without RESULT_COLLECTOR_STATS_EN, the stat_results and stat_ovf ports and their counters SHALL be absent.

Structure
REQ-036 Package result_pkg SHALL hold the DEPTH and DATA_W defaults and the entry struct typedef (data, ovf, ovf_valid).
REQ-037 Storage SHALL be a sub-module, result_buf_ram, with 1 write port, 1 flag-update port and 1 registered read port; pointer and control logic SHALL remain in result_collector.

Verification
REQ-038 Bench SHALL cover: we with c_in=32'h3F800000 in cycle 0, then we_ov with overflow_in=0 in cycle 1 -> rd_valid=1 in cycle 2, rd_data=32'h3F800000, rd_ovf=0.
REQ-039 Bench SHALL cover: rd_ready=0, 8 pairs written, then a 9th we -> full=1, level=8, drop_err=1; popping all 8 returns the data in order.
REQ-040 Bench SHALL cover: we_ov with overflow_in=1 on an empty buffer -> orphan_err=1, level=0, rd_valid=0.
REQ-041 Bench SHALL cover: 3 products written with no flags -> rd_valid=0; then 3 we_ov values 1,0,1 -> the entries pop with rd_ovf=1,0,1.
REQ-042 Bench SHALL cover: flush with level=5 and simultaneous we -> level=0 next cycle, rd_valid=0, and drop_err unchanged.
REQ-043 Bench SHALL cover: with RESULT_COLLECTOR_STATS_EN defined, 20 pops of which 7 have rd_ovf=1 -> stat_results=20, stat_ovf=7.
